// File: rtl/cache_ctrl_pkg.sv
// Shared types and address-field constants for the cache controller slice.
// Build option: define CACHE_WB_EN for write-back (dirty bits + victim flush).
package cache_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 21;
  localparam int IDX_W  = 6;
  localparam int WORD_W = 3;
  localparam int OFFS_W = 5;
  localparam int LINES  = 64;

  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 11;
  localparam int IDX_MSB  = 10;
  localparam int IDX_LSB  = 5;
  localparam int WORD_MSB = 4;
  localparam int WORD_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_e;

  // Byte address of the first byte of a line.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_ctrl_tag_store.sv
// Tag/valid(/dirty) array: combinational read port, synchronous fill and dirty-set.
// Dirty storage exists only when CACHE_WB_EN is defined.
module cache_tag_store
  import cache_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic             rd_dirty,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             dirty_en,
  input  logic [IDX_W-1:0] dirty_idx
);

  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;

  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    if (fill_en) begin
      tag_d[fill_idx]   = fill_tag;
      valid_d[fill_idx] = 1'b1;
    end
  end

  // Tags need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

`ifdef CACHE_WB_EN
  logic [LINES-1:0] dirty_q;
  logic [LINES-1:0] dirty_d;

  always_comb begin
    dirty_d = dirty_q;
    if (fill_en)  dirty_d[fill_idx]  = 1'b0;
    if (dirty_en) dirty_d[dirty_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) dirty_q <= '0;
    else     dirty_q <= dirty_d;
  end

  assign rd_dirty = dirty_q[rd_idx];
`else
  logic unused_dirty;
  assign unused_dirty = dirty_en ^ (^dirty_idx);
  assign rd_dirty     = 1'b0;
`endif

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: hit/miss FSM driving refill and write-back engines.
// Build option: CACHE_WB_EN enables dirty tracking, WRITEBACK state and wb_start/wb_addr.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  output logic                    cpu_ready,
  output logic [IDX_W+WORD_W-1:0] cache_word_addr,
  output logic                    cache_word_we,
  output logic                    alloc_start,
  input  logic                    alloc_done,
  output logic                    wb_start,
  output logic [ADDR_W-1:0]       wb_addr,
  input  logic                    wb_done,
  output logic [ADDR_W-1:0]       lat_addr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              lat_we_q, lat_we_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              word_we_q, word_we_d;
  logic              alloc_start_q, alloc_start_d;

  logic [IDX_W-1:0]  lat_idx;
  logic [TAG_W-1:0]  lat_tag;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              rd_dirty;
  logic              hit;
  logic              fill_en;
  logic              dirty_en;

  assign lat_idx = lat_addr_q[IDX_MSB:IDX_LSB];
  assign lat_tag = lat_addr_q[TAG_MSB:TAG_LSB];
  assign hit     = rd_valid && (rd_tag == lat_tag);

  cache_tag_store u_tag_store (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (lat_idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .fill_en   (fill_en),
    .fill_idx  (lat_idx),
    .fill_tag  (lat_tag),
    .dirty_en  (dirty_en),
    .dirty_idx (lat_idx)
  );

`ifdef CACHE_WB_EN
  logic              wb_start_q, wb_start_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
`endif

  // Strobes are registered, so each appears the cycle after the state that decides it.
  always_comb begin
    state_d       = state_q;
    lat_addr_d    = lat_addr_q;
    lat_we_d      = lat_we_q;
    cpu_ready_d   = 1'b0;
    word_we_d     = 1'b0;
    alloc_start_d = 1'b0;
    fill_en       = 1'b0;
    dirty_en      = 1'b0;
`ifdef CACHE_WB_EN
    wb_start_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          lat_addr_d = cpu_addr;
          lat_we_d   = cpu_we;
          state_d    = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (hit) begin
          cpu_ready_d = 1'b1;
          word_we_d   = lat_we_q;
          dirty_en    = lat_we_q;
          state_d     = ST_IDLE;
`ifdef CACHE_WB_EN
        end else if (rd_valid && rd_dirty) begin
          wb_start_d = 1'b1;
          wb_addr_d  = line_addr(rd_tag, lat_idx);
          state_d    = ST_WRITEBACK;
`endif
        end else begin
          alloc_start_d = 1'b1;
          state_d       = ST_ALLOCATE;
        end
      end
`ifdef CACHE_WB_EN
      ST_WRITEBACK: begin
        if (wb_done) begin
          alloc_start_d = 1'b1;
          state_d       = ST_ALLOCATE;
        end
      end
`endif
      ST_ALLOCATE: begin
        if (alloc_done) begin
          fill_en = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lat_addr_q    <= '0;
      lat_we_q      <= 1'b0;
      cpu_ready_q   <= 1'b0;
      word_we_q     <= 1'b0;
      alloc_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_addr_q    <= lat_addr_d;
      lat_we_q      <= lat_we_d;
      cpu_ready_q   <= cpu_ready_d;
      word_we_q     <= word_we_d;
      alloc_start_q <= alloc_start_d;
    end
  end

`ifdef CACHE_WB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_start_q <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      wb_start_q <= wb_start_d;
      wb_addr_q  <= wb_addr_d;
    end
  end

  assign wb_start = wb_start_q;
  assign wb_addr  = wb_addr_q;
`else
  logic unused_wb;
  assign unused_wb = wb_done ^ rd_dirty;
  assign wb_start  = 1'b0;
  assign wb_addr   = '0;
`endif

  assign cpu_ready       = cpu_ready_q;
  assign cache_word_we   = word_we_q;
  assign alloc_start     = alloc_start_q;
  assign lat_addr        = lat_addr_q;
  assign cache_word_addr = {lat_addr_q[IDX_MSB:IDX_LSB], lat_addr_q[WORD_MSB:WORD_LSB]};

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios then random accesses
// against a per-line reference model; honours CACHE_WB_EN like the design.
module tb_cache_ctrl;

`ifdef CACHE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [8:0]  cache_word_addr;
  logic        cache_word_we;
  logic        alloc_start;
  logic        alloc_done;
  logic        wb_start;
  logic [31:0] wb_addr;
  logic        wb_done;
  logic [31:0] lat_addr;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: what each of the 64 lines currently holds.
  logic [20:0] m_tag   [64];
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [31:0] last_addr;

  cache_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_ready       (cpu_ready),
    .cache_word_addr (cache_word_addr),
    .cache_word_we   (cache_word_we),
    .alloc_start     (alloc_start),
    .alloc_done      (alloc_done),
    .wb_start        (wb_start),
    .wb_addr         (wb_addr),
    .wb_done         (wb_done),
    .lat_addr        (lat_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic checkQuiet(input string pfx);
    checkOutput({pfx, ".cpu_ready"},     32'(cpu_ready),     32'd0);
    checkOutput({pfx, ".cache_word_we"}, 32'(cache_word_we), 32'd0);
    checkOutput({pfx, ".alloc_start"},   32'(alloc_start),   32'd0);
    checkOutput({pfx, ".wb_start"},      32'(wb_start),      32'd0);
  endtask

  task automatic modelClear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Idle cycles in IDLE; optionally fire both completion inputs to prove they are ignored.
  task automatic idleCycles(input int cycles, input bit spurious);
    for (int k = 0; k < cycles; k++) begin
      cpu_req    = 1'b0;
      alloc_done = spurious;
      wb_done    = spurious;
      @(negedge clk);
      checkQuiet("idle");
      checkOutput("idle.lat_addr", lat_addr, last_addr);
    end
    alloc_done = 1'b0;
    wb_done    = 1'b0;
  endtask

  // One CPU access; called at a negedge with the DUT in IDLE. Samples are numbered
  // by negedges after the request edge, so a hit shows cpu_ready at sample 2.
  task automatic applyStimulus(input bit we, input logic [31:0] addr);
    int          idx;
    logic [20:0] t;
    bit          hit, wbneed, finished;
    logic [31:0] victim;
    int          exp_wb, exp_alloc, exp_ready, wb_done_at, alloc_done_at;

    idx    = int'(addr[10:5]);
    t      = addr[31:11];
    hit    = m_valid[idx] && (m_tag[idx] == t);
    wbneed = WB_EN && !hit && m_valid[idx] && m_dirty[idx];
    victim = {m_tag[idx], addr[10:5], 5'b00000};

    exp_wb        = wbneed ? 2 : -1;
    exp_alloc     = (!hit && !wbneed) ? 2 : -1;
    exp_ready     = hit ? 2 : -1;
    wb_done_at    = -1;
    alloc_done_at = -1;
    finished      = 1'b0;

    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    for (int n = 1; n <= 40 && !finished; n++) begin
      @(negedge clk);
      alloc_done = 1'b0;
      wb_done    = 1'b0;
      checkOutput("wb_start",        32'(wb_start),        32'(n == exp_wb));
      checkOutput("alloc_start",     32'(alloc_start),     32'(n == exp_alloc));
      checkOutput("cpu_ready",       32'(cpu_ready),       32'(n == exp_ready));
      checkOutput("cache_word_we",   32'(cache_word_we),   32'((n == exp_ready) && we));
      checkOutput("lat_addr",        lat_addr,             addr);
      checkOutput("cache_word_addr", 32'(cache_word_addr), 32'(addr[10:2]));
      if (n == exp_wb) begin
        checkOutput("wb_addr", wb_addr, victim);
        wb_done_at = n + int'($urandom_range(1, 4));
      end
      if (n == wb_done_at) begin
        wb_done   = 1'b1;
        exp_alloc = n + 1;
      end
      if (n == exp_alloc) alloc_done_at = n + int'($urandom_range(1, 4));
      if (n == alloc_done_at) begin
        alloc_done = 1'b1;
        exp_ready  = n + 2;
      end
      if (n == exp_ready) finished = 1'b1;
      // While busy, a stray request must be ignored.
      cpu_req  = finished ? 1'b0 : 1'($urandom_range(0, 1));
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_addr = finished ? addr : $urandom;
    end
    checkOutput("access_completed", 32'(finished), 32'd1);

    if (!hit) begin
      m_tag[idx]   = t;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (we) m_dirty[idx] = 1'b1;
    last_addr = addr;
  endtask

  initial begin
    logic [31:0] a;

    rst        = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    alloc_done = 1'b0;
    wb_done    = 1'b0;
    last_addr  = '0;
    modelClear();

    repeat (3) @(negedge clk);
    checkQuiet("reset");
    checkOutput("reset.lat_addr",        lat_addr,             32'h0);
    checkOutput("reset.wb_addr",         wb_addr,              32'h0);
    checkOutput("reset.cache_word_addr", 32'(cache_word_addr), 32'h0);
    rst = 1'b0;
    idleCycles(1, 1'b0);

    $display("[TB] cold read, hit, write hit, dirty conflict");
    applyStimulus(1'b0, 32'h0000_0040);
    applyStimulus(1'b0, 32'h0000_0044);
    applyStimulus(1'b1, 32'h0000_0044);
    applyStimulus(1'b0, 32'h0000_0844);

    $display("[TB] spurious completions while idle");
    idleCycles(4, 1'b1);

    $display("[TB] reset during a refill");
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0040;
    @(negedge clk);
    cpu_req = 1'b0;
    checkQuiet("rstmiss.s1");
    @(negedge clk);
    checkOutput("rstmiss.alloc_start", 32'(alloc_start), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkQuiet("rstmiss.after");
    checkOutput("rstmiss.lat_addr",        lat_addr,             32'h0);
    checkOutput("rstmiss.cache_word_addr", 32'(cache_word_addr), 32'h0);
    checkOutput("rstmiss.wb_addr",         wb_addr,              32'h0);
    rst = 1'b0;
    modelClear();
    last_addr = '0;
    idleCycles(1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0040);

    $display("[TB] random accesses over a small conflict set");
    for (int i = 0; i < 150; i++) begin
      a         = $urandom;
      a[31:11]  = 21'($urandom_range(0, 3));
      a[10:5]   = 6'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), a);
      if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
